// File: rtl/dyser_cfg_pkg.sv
// Shared definitions for the DySER configuration loader.
// DYSER_CFG_CHECKSUM_EN adds the CHECK state (XOR checksum word after the block).
package dyser_cfg_pkg;

    // Width of one DySER config word; dyser uses the same value.
    localparam int CFG_WIDTH_DEF = 21;
    // Config words per fabric load.
    localparam int NUM_WORDS_DEF = 17;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WRITE  = 3'd2,
`ifdef DYSER_CFG_CHECKSUM_EN
        ST_CHECK  = 3'd4,
`endif
        ST_FINISH = 3'd3
    } ld_state_e;

endpackage

// File: rtl/dyser_cfg_loader.sv
// Autonomous config sequencer: fetches NUM_WORDS words from a word-addressed
// memory port and streams them into dyser config_bits/config_en, holding
// send_block high while busy.
// DYSER_CFG_CHECKSUM_EN: fold written words into an XOR accumulator and verify
// it against an extra word fetched at base+NUM_WORDS before signalling done.
import dyser_cfg_pkg::*;

module dyser_cfg_loader #(
    parameter int NUM_WORDS  = NUM_WORDS_DEF,
    parameter int CFG_WIDTH  = CFG_WIDTH_DEF,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  abort,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [CFG_WIDTH-1:0]  mem_data,
    output logic [CFG_WIDTH-1:0]  config_bits,
    output logic                  config_en,
    output logic                  send_block,
    output logic                  done,
    output logic                  error
);

    // idx must also reach NUM_WORDS so the checksum fetch reuses the adder.
    localparam int IDX_W = (NUM_WORDS < 2) ? 1 : $clog2(NUM_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    ld_state_e               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CFG_WIDTH-1:0]    cfg_q, cfg_d;
    logic                    err_q, err_d;
`ifdef DYSER_CFG_CHECKSUM_EN
    logic [CFG_WIDTH-1:0]    acc_q, acc_d;
`endif

    // State and datapath registers; rst clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            cfg_q   <= '0;
            err_q   <= 1'b0;
`ifdef DYSER_CFG_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
`ifdef DYSER_CFG_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Next-state and handshake outputs; abort overrides everything outside IDLE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        cfg_d     = cfg_q;
        err_d     = err_q;
`ifdef DYSER_CFG_CHECKSUM_EN
        acc_d     = acc_q;
`endif
        mem_req   = 1'b0;
        config_en = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    idx_d   = '0;
                    err_d   = 1'b0;
`ifdef DYSER_CFG_CHECKSUM_EN
                    acc_d   = '0;
`endif
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_valid) begin
                    cfg_d   = mem_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                config_en = 1'b1;
`ifdef DYSER_CFG_CHECKSUM_EN
                acc_d     = acc_q ^ cfg_q;
`endif
                if (idx_q == LAST_IDX) begin
`ifdef DYSER_CFG_CHECKSUM_EN
                    // Step idx to NUM_WORDS so mem_addr points at the checksum word.
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_CHECK;
`else
                    state_d = ST_FINISH;
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_FETCH;
                end
            end
`ifdef DYSER_CFG_CHECKSUM_EN
            ST_CHECK: begin
                mem_req = 1'b1;
                if (mem_valid) begin
                    if (mem_data == acc_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            idx_d     = idx_q;
            cfg_d     = cfg_q;
`ifdef DYSER_CFG_CHECKSUM_EN
            acc_d     = acc_q;
`endif
            err_d     = 1'b1;
            mem_req   = 1'b0;
            config_en = 1'b0;
            done      = 1'b0;
        end
    end

    // Address wraps modulo 2^ADDR_WIDTH by truncation.
    assign mem_addr    = base_q + ADDR_WIDTH'(idx_q);
    assign config_bits = cfg_q;
    assign send_block  = (state_q != ST_IDLE);
    assign error       = err_q;

endmodule

// File: tb/tb_dyser_cfg_loader.sv
// Directed bench for dyser_cfg_loader: basic load, wait states, address wrap,
// abort/restart, ignored start, async reset, and checksum when enabled.
module tb_dyser_cfg_loader;

`ifdef DYSER_CFG_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int NW = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic        abort = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_valid;
    logic [20:0] mem_data;
    logic [20:0] config_bits;
    logic        config_en;
    logic        send_block;
    logic        done;
    logic        error;

    dyser_cfg_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .abort(abort),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
        .mem_data(mem_data), .config_bits(config_bits), .config_en(config_en),
        .send_block(send_block), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Memory model with an optional stall on one address.
    logic [20:0] mem [256];
    logic        stall_en = 1'b0;
    logic [7:0]  stall_addr = 8'h00;
    int          stall_n = 0;
    int          wait_cnt = 0;

    assign mem_valid = mem_req && !(stall_en && mem_addr == stall_addr && wait_cnt < stall_n);
    assign mem_data  = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_valid && mem_addr == stall_addr) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor sampled on the falling edge.
    logic [20:0] en_q [$];
    logic [7:0]  fa_q [$];
    int done_cnt, done_off, sb_cnt, first_req_off, unstable, n15, start_cyc;
    logic prev_wait = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    always @(negedge clk) begin
        if (config_en) en_q.push_back(config_bits);
        if (mem_req && mem_valid) fa_q.push_back(mem_addr);
        if (done) begin done_cnt++; done_off = cyc - start_cyc; end
        if (send_block) sb_cnt++;
        if (mem_req && first_req_off < 0) first_req_off = cyc - start_cyc;
        if (prev_wait && !(mem_req && mem_addr == prev_addr)) unstable++;
        if (mem_req && mem_addr == 8'h15) n15++;
        prev_wait = mem_req && !mem_valid;
        prev_addr = mem_addr;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        en_q.delete();
        fa_q.delete();
        done_cnt = 0; done_off = -1; sb_cnt = 0; first_req_off = -1;
        unstable = 0; n15 = 0;
    endtask

    task automatic do_start(input logic [7:0] b);
        @(posedge clk); #1;
        base_addr = b; start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Check a completed load against the memory image and timing.
    task automatic check_load(input string tag, input logic [7:0] b, input int exp_off);
        logic [7:0] a;
        chk({tag, "_ncfg"}, 32'(en_q.size()), 32'(NW));
        chk({tag, "_nfetch"}, 32'(fa_q.size()), 32'(NW + CHK));
        for (int k = 0; k < NW && k < en_q.size() && k < fa_q.size(); k++) begin
            a = 8'(int'(b) + k);
            chk($sformatf("%s_addr%0d", tag, k), 32'(fa_q[k]), 32'(a));
            chk($sformatf("%s_data%0d", tag, k), 32'(en_q[k]), 32'(mem[a]));
        end
        chk({tag, "_ndone"}, 32'(done_cnt), 32'd1);
        chk({tag, "_tdone"}, 32'(done_off), 32'(exp_off));
        chk({tag, "_sb"}, 32'(sb_cnt), 32'(exp_off));
        chk({tag, "_req1"}, 32'(first_req_off), 32'd1);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_hold"}, 32'(config_bits), 32'(mem[8'(int'(b) + NW - 1)]));
        chk({tag, "_idle"}, 32'(send_block), 32'd0);
    endtask

    logic [20:0] tbl [NW] = '{21'h000000, 21'h000080, 21'h040980, 21'h1A2B3C, 21'h0F0F0F,
                              21'h155555, 21'h0AAAAA, 21'h1FFFFF, 21'h000001, 21'h100000,
                              21'h012345, 21'h0FEDCB, 21'h13579B, 21'h02468A, 21'h1C0FFE,
                              21'h0BEEF0, 21'h000010};

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 21'((a * 32'h2F1D3) ^ 32'h15A5A);
        for (int k = 0; k < NW; k++) mem[8'h10 + k] = tbl[k];
        clear_mon();
        start_cyc = 0;

        // Reset values while rst is held.
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cfg_bits", 32'(config_bits), 32'd0);
        chk("rst_cfg_en", 32'(config_en), 32'd0);
        chk("rst_send_block", 32'(send_block), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // abort in IDLE has no effect
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_err", 32'(error), 32'd0);
        chk("idle_abort_sb", 32'(send_block), 32'd0);

        // Basic load with same-cycle mem_valid.
        clear_mon();
        do_start(8'h10);
        repeat (45) @(posedge clk);
        check_load("basic", 8'h10, 35 + CHK);

        // Start pulsed mid-load is ignored.
        clear_mon();
        do_start(8'h10);
        repeat (8) @(posedge clk);
        #1 base_addr = 8'h40; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (60) @(posedge clk);
        check_load("ign", 8'h10, 35 + CHK);

        // Three wait cycles on word 5 (address 0x15).
        clear_mon();
        stall_en = 1'b1; stall_addr = 8'h15; stall_n = 3;
        do_start(8'h10);
        repeat (50) @(posedge clk);
        stall_en = 1'b0;
        check_load("wait", 8'h10, 38 + CHK);
        chk("wait_stable", 32'(unstable), 32'd0);
        chk("wait_n15", 32'(n15), 32'd4);

        // Address wrap from 0xF8.
        clear_mon();
        do_start(8'hF8);
        repeat (45) @(posedge clk);
        check_load("wrap", 8'hF8, 35 + CHK);

        // Abort during FETCH of word 7, then restart.
        clear_mon();
        do_start(8'h10);
        while (cyc != start_cyc + 15) begin @(posedge clk); #1; end
        chk("abort_addr", 32'(mem_addr), 32'h17);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_sb", 32'(send_block), 32'd0);
        chk("abort_err", 32'(error), 32'd1);
        repeat (5) @(posedge clk);
        chk("abort_ncfg", 32'(en_q.size()), 32'd7);
        chk("abort_done", 32'(done_cnt), 32'd0);
        clear_mon();
        do_start(8'h10);
        @(negedge clk);
        chk("restart_err", 32'(error), 32'd0);
        repeat (45) @(posedge clk);
        check_load("restart", 8'h10, 35 + CHK);

`ifdef DYSER_CFG_CHECKSUM_EN
        begin
            logic [20:0] x;
            x = '0;
            for (int k = 0; k < NW; k++) x ^= tbl[k];
            mem[8'h10 + NW] = x;
            clear_mon();
            do_start(8'h10);
            repeat (45) @(posedge clk);
            chk("cks_ok_done", 32'(done_cnt), 32'd1);
            chk("cks_ok_err", 32'(error), 32'd0);
            mem[8'h10 + NW] = 21'h1FFFFF;
            clear_mon();
            do_start(8'h10);
            repeat (45) @(posedge clk);
            chk("cks_bad_done", 32'(done_cnt), 32'd0);
            chk("cks_bad_err", 32'(error), 32'(x != 21'h1FFFFF));
            chk("cks_bad_ncfg", 32'(en_q.size()), 32'(NW));
        end
`endif

        // Async reset mid-load.
        clear_mon();
        do_start(8'h10);
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_cfg_bits", 32'(config_bits), 32'd0);
        chk("arst_cfg_en", 32'(config_en), 32'd0);
        chk("arst_sb", 32'(send_block), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(error), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
